// File: rtl/ninjakun_tile_layer_if.sv
// Bus between the tile layer, the CRTC counters, tile VRAM, tile ROM and the colour mixer.
interface ninjakun_tile_layer_if #(parameter int CAD_W = 13);
  logic [8:0]       PH;
  logic [8:0]       PV;
  logic [7:0]       SCX;
  logic [7:0]       SCY;
  logic             LAYEN;
  logic [9:0]       VAD;
  logic [15:0]      VDT;
  logic [CAD_W-1:0] CAD;
  logic [31:0]      CDT;
  logic [8:0]       PIXOUT;
  logic             OPQ;

  modport master (input PH, PV, SCX, SCY, LAYEN, VDT, CDT,
                  output VAD, CAD, PIXOUT, OPQ);
  modport slave  (output PH, PV, SCX, SCY, LAYEN, VDT, CDT,
                  input VAD, CAD, PIXOUT, OPQ);
endinterface

// File: rtl/ninjakun_tile_layer.sv
// Tilemap scanline generator: line-latched scroll, VRAM/ROM fetch keyed on the tile phase, 4bpp shifter.
// Optional per-tile X flip when NJTILE_FLIPX_EN is defined.
module ninjakun_tile_layer #(
  parameter logic [8:0] HOFS     = 9'd9,
  parameter logic [8:0] VOFS     = 9'd32,
  parameter int         CHR_W    = 10,
  parameter int         CAD_W    = 13,
  parameter int         CHR_BASE = 0,
  parameter logic [8:0] LATCH_H  = 9'd256
) (
  input logic                   VCLK,
  input logic                   RESET_N,
  ninjakun_tile_layer_if.master bus
);
  localparam logic [CAD_W-1:0] BASE = CAD_W'(CHR_BASE) << (CHR_W + 3);

  logic [7:0]  sxl, syl;
  logic [15:0] atr;
  logic [31:0] sh;
  logic [3:0]  pal;
  logic        pri, flx;

  logic [8:0]  posh, posv;
  logic [2:0]  p, idx;
  logic [3:0]  nib;
  logic [9:0]  chr;

  assign posh = bus.PH + {1'b0, sxl} + HOFS;
  assign posv = bus.PV + {1'b0, syl} + VOFS;
  assign p    = posh[2:0];
  assign chr  = {atr[13:12], atr[7:0]};

  // Nibble pairs are swapped within each byte; flip walks the same order backwards.
  assign idx = flx ? {~p[2:1], p[0]} : {p[2:1], ~p[0]};
  assign nib = sh[{idx, 2'b00} +: 4];

  logic unused_bits;
  assign unused_bits = &{1'b0, posh[8], posv[8], atr[14], chr};

  always_ff @(posedge VCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sxl        <= '0;
      syl        <= '0;
      atr        <= '0;
      sh         <= '0;
      pal        <= '0;
      pri        <= 1'b0;
      flx        <= 1'b0;
      bus.VAD    <= '0;
      bus.CAD    <= '0;
      bus.PIXOUT <= '0;
      bus.OPQ    <= 1'b0;
    end else begin
      if (bus.PH == LATCH_H) begin
        sxl <= bus.SCX;
        syl <= bus.SCY;
      end
      case (p)
        3'd1: bus.VAD <= {posv[7:3], posh[7:3]};
        3'd3: atr     <= bus.VDT;
        3'd4: bus.CAD <= BASE | CAD_W'({chr[CHR_W-1:0], posv[2:0]});
        3'd7: begin
          sh  <= bus.CDT;
          pal <= atr[11:8];
          pri <= atr[15];
`ifdef NJTILE_FLIPX_EN
          flx <= atr[14];
`else
          flx <= 1'b0;
`endif
        end
        default: ;
      endcase
      bus.PIXOUT <= {pri, pal, nib};
      bus.OPQ    <= (nib != 4'd0) & bus.LAYEN;
    end
  end
endmodule

// File: tb/tb_ninjakun_tile_layer.sv
// Directed bench for ninjakun_tile_layer: reset, fetch order, scroll latch, flip, priority/enable, wrap.
module tb_ninjakun_tile_layer;
  localparam int CAD_W = 13;

  logic VCLK = 1'b0;
  logic RESET_N = 1'b1;
  int checks = 0;
  int errors = 0;

  ninjakun_tile_layer_if #(.CAD_W(CAD_W)) bus();
  ninjakun_tile_layer #(.CAD_W(CAD_W)) dut (.VCLK(VCLK), .RESET_N(RESET_N), .bus(bus));

  always #5 VCLK = ~VCLK;

  // Inputs seen by the edge just taken, and the bench's own copy of the latched scroll.
  logic [8:0] ph_q, pv_q;
  logic       lay_q;
  logic [7:0] sx = 8'd0, sy = 8'd0;

  // With CDT = 32'h32541076 the fetch order gives tile sequences 7,6,1,0,5,4,3,2 / flipped 2,3,4,5,0,1,6,7.
  logic [3:0] seq_n [8] = '{4'd7, 4'd6, 4'd1, 4'd0, 4'd5, 4'd4, 4'd3, 4'd2};
  logic [3:0] seq_f [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd6, 4'd7};

  function automatic logic [8:0] poshq();
    return ph_q + {1'b0, sx} + 9'd9;
  endfunction
  function automatic logic [8:0] posvq();
    return pv_q + {1'b0, sy} + 9'd32;
  endfunction

  task automatic cyc();
    ph_q  = bus.PH;
    pv_q  = bus.PV;
    lay_q = bus.LAYEN;
    @(posedge VCLK);
    #1;
    bus.PH = (bus.PH == 9'd383) ? 9'd0 : bus.PH + 9'd1;
  endtask

  task automatic test_reset();
    logic [8:0] h;
    bus.PH = 0; bus.PV = 0; bus.SCX = 0; bus.SCY = 0; bus.LAYEN = 1'b1;
    bus.VDT = 16'h0305; bus.CDT = 32'h32541076;
    #3 RESET_N = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.PH  = 9'($urandom_range(0, 383));
      bus.VDT = 16'($urandom);
      @(posedge VCLK); #1;
      checks++;
      if ({bus.PIXOUT, bus.OPQ, bus.VAD, bus.CAD} !== '0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d PIXOUT=%h OPQ=%b VAD=%h CAD=%h want all 0",
                 i, bus.PIXOUT, bus.OPQ, bus.VAD, bus.CAD);
      end
    end
    bus.VDT = 16'h0305;
    bus.PH  = 9'd2;
    RESET_N = 1'b1;
    // First edges after release run phases 3,4,5,6,7,0 before any VAD fetch.
    for (int i = 0; i < 6; i++) begin
      cyc();
      h = poshq();
      if (i < 5) begin
        checks++;
        if (bus.PIXOUT !== 9'h0 || bus.OPQ !== 1'b0) begin
          errors++;
          $display("FAIL release_pix p=%0d PIXOUT=%h OPQ=%b want 000/0", h[2:0], bus.PIXOUT, bus.OPQ);
        end
      end
      checks++;
      if (bus.VAD !== 10'h0) begin
        errors++;
        $display("FAIL release_vad p=%0d VAD=%h want 000", h[2:0], bus.VAD);
      end
      if (i == 0) begin
        checks++;
        if (bus.CAD !== '0) begin
          errors++;
          $display("FAIL release_cad CAD=%h want 0000", bus.CAD);
        end
      end
    end
  endtask

  task automatic test_basic_fetch();
    logic [8:0] h, v, e;
    bus.PV = 0; bus.VDT = 16'h0305; bus.CDT = 32'h32541076; bus.LAYEN = 1'b1;
    for (int i = 0; i < 24; i++) cyc();
    for (int i = 0; i < 64; i++) begin
      cyc();
      h = poshq(); v = posvq();
      e = {1'b0, 4'h3, seq_n[h[2:0]]};
      checks++;
      if (bus.PIXOUT !== e || bus.OPQ !== (seq_n[h[2:0]] != 4'd0)) begin
        errors++;
        $display("FAIL basic_pix p=%0d PIXOUT=%h OPQ=%b want %h/%b", h[2:0], bus.PIXOUT, bus.OPQ,
                 e, seq_n[h[2:0]] != 4'd0);
      end
      checks++;
      if (bus.CAD !== 13'h28) begin
        errors++;
        $display("FAIL basic_cad CAD=%h want 0028", bus.CAD);
      end
      if (h[2:0] == 3'd1) begin
        checks++;
        if (bus.VAD !== {v[7:3], h[7:3]}) begin
          errors++;
          $display("FAIL basic_vad PH=%0d VAD=%h want %h", ph_q, bus.VAD, {v[7:3], h[7:3]});
        end
      end
    end
  endtask

  task automatic test_scroll_latch();
    logic [8:0] h0;
    logic [4:0] c;
    int n;
    n = 0;
    while (bus.PH != 9'd100 && n < 400) begin cyc(); n++; end
    bus.SCX = 8'd8;
    n = 0;
    while (n < 400) begin
      cyc(); n++;
      h0 = ph_q + 9'd9;
      if (h0[2:0] == 3'd1) begin
        checks++;
        if (bus.VAD[4:0] !== h0[7:3]) begin
          errors++;
          $display("FAIL scroll_same_line PH=%0d col=%0d want %0d", ph_q, bus.VAD[4:0], h0[7:3]);
        end
      end
      if (ph_q == 9'd256) break;
    end
    sx = 8'd8;
    n = 0;
    while (n < 400) begin
      cyc(); n++;
      h0 = ph_q + 9'd9;
      c  = h0[7:3] + 5'd1;
      if (h0[2:0] == 3'd1) begin
        checks++;
        if (bus.VAD[4:0] !== c) begin
          errors++;
          $display("FAIL scroll_next_line PH=%0d col=%0d want %0d", ph_q, bus.VAD[4:0], c);
        end
      end
      if (ph_q == 9'd250) break;
    end
  endtask

  task automatic test_flip();
    logic [8:0] h, e;
    logic [3:0] nb;
    bus.VDT = 16'h4305;
    for (int i = 0; i < 24; i++) cyc();
    for (int i = 0; i < 32; i++) begin
      cyc();
      h = poshq();
`ifdef NJTILE_FLIPX_EN
      nb = seq_f[h[2:0]];
`else
      nb = seq_n[h[2:0]];
`endif
      e = {1'b0, 4'h3, nb};
      checks++;
      if (bus.PIXOUT !== e) begin
        errors++;
        $display("FAIL flip_pix p=%0d PIXOUT=%h want %h", h[2:0], bus.PIXOUT, e);
      end
    end
  endtask

  task automatic test_prio_enable();
    logic [8:0] h, e;
    logic       o;
    bus.VDT = 16'h8305;
    for (int i = 0; i < 24; i++) cyc();
    for (int i = 0; i < 24; i++) begin
      bus.LAYEN = !(i >= 8 && i < 11);
      cyc();
      h = poshq();
      e = {1'b1, 4'h3, seq_n[h[2:0]]};
      o = (seq_n[h[2:0]] != 4'd0) && (i < 8 || i >= 11);
      checks++;
      if (bus.PIXOUT !== e || bus.OPQ !== o) begin
        errors++;
        $display("FAIL prio_en cyc%0d PIXOUT=%h OPQ=%b want %h/%b", i, bus.PIXOUT, bus.OPQ, e, o);
      end
    end
    bus.LAYEN = 1'b1;
  endtask

  task automatic test_wrap();
    logic [8:0] h;
    int n;
    bus.SCY = 8'hFF; bus.PV = 9'd300;
    n = 0;
    while (n < 400) begin cyc(); n++; if (ph_q == 9'd256) break; end
    sy = 8'hFF;
    for (int i = 0; i < 16; i++) cyc();
    for (int i = 0; i < 32; i++) begin
      cyc();
      h = poshq();
      checks++;
      if (bus.CAD !== 13'h2B) begin
        errors++;
        $display("FAIL wrap_cad CAD=%h want 002b", bus.CAD);
      end
      if (h[2:0] == 3'd1) begin
        checks++;
        if (bus.VAD !== {5'd9, h[7:3]}) begin
          errors++;
          $display("FAIL wrap_vad PH=%0d VAD=%h want %h", ph_q, bus.VAD, {5'd9, h[7:3]});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] h;
    bit seen;
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({bus.PIXOUT, bus.OPQ, bus.VAD, bus.CAD} !== '0) begin
      errors++;
      $display("FAIL reset_mid PIXOUT=%h OPQ=%b VAD=%h CAD=%h want all 0",
               bus.PIXOUT, bus.OPQ, bus.VAD, bus.CAD);
    end
    @(posedge VCLK); #1;
    sx = 8'd0; sy = 8'd0;
    bus.PH  = 9'd2;
    RESET_N = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      h = poshq();
      if (h[2:0] == 3'd4) begin
        // Cleared Y scroll: POSV = 300+32 = 332, fine row 4.
        checks++;
        if (bus.CAD !== 13'h2C) begin
          errors++;
          $display("FAIL reset_mid_cad CAD=%h want 002c", bus.CAD);
        end
      end
      if (h[2:0] == 3'd1) begin
        seen = 1'b1;
        checks++;
        if (bus.VAD !== {5'd9, h[7:3]}) begin
          errors++;
          $display("FAIL reset_mid_vad VAD=%h want %h", bus.VAD, {5'd9, h[7:3]});
        end
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL reset_mid_fetch no p=1 edge seen want 1");
    end
  endtask

  initial begin
    test_reset();
    test_basic_fetch();
    test_scroll_latch();
    test_flip();
    test_prio_enable();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
